// File: rtl/bram_pkg.sv
// Shared defaults and state encoding for the burst-read block RAM.
package bram_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 13;
    localparam int RD_LAT_DEF = 10;
    localparam int LEN_W_DEF  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;
endpackage

// File: rtl/bram_lat_pipe.sv
// Fixed-depth delay line with synchronous clear; DEPTH=0 is a wire.
module bram_lat_pipe #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 34
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = clk_i ^ clr_i;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] sr_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (clr_i) begin
                    for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/bram_burst.sv
// Byte-strobed block RAM with pipelined, wrapping burst reads.
module bram_burst
    import bram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WE,
    input  logic [ADDR_W-1:0]   REQ_ADDR,
    input  logic [LEN_W-1:0]    REQ_LEN,
    input  logic [DATA_W/8-1:0] REQ_WSTB,
    input  logic [DATA_W-1:0]   REQ_WDATA,
    output logic                RD_VALID,
    output logic [DATA_W-1:0]   RD_DATA,
    output logic                RD_LAST
);
    localparam int NB = DATA_W / 8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                rdy_en_q;
    logic                acc, wr_en;
    logic                rd_en, rd_last;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   mem_q [2**ADDR_W];
    logic [DATA_W-1:0]   dout_q;
    logic                v0_q, l0_q;
    logic [DATA_W+1:0]   pipe_q;

    assign REQ_READY = (state_q == IDLE) && rdy_en_q;
    assign acc       = REQ_VALID && REQ_READY && RSTn;
    assign wr_en     = acc && REQ_WE;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        rd_addr = REQ_ADDR;
        rd_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc && !REQ_WE) begin
                    rd_en   = 1'b1;
                    rd_last = (REQ_LEN == '0);
                    addr_d  = REQ_ADDR + ADDR_W'(1);
                    cnt_d   = REQ_LEN;
                    if (REQ_LEN != '0) state_d = BURST;
                end
            end
            BURST: begin
                // cnt_q holds the reads still to issue
                rd_en   = 1'b1;
                rd_addr = addr_q;
                rd_last = (cnt_q == LEN_W'(1));
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - LEN_W'(1);
                if (rd_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
            v0_q     <= 1'b0;
            l0_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
            v0_q     <= rd_en;
            l0_q     <= rd_last;
        end
    end

    // Unreset array with registered read port maps onto block RAM
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (REQ_WSTB[b]) mem_q[REQ_ADDR][8*b +: 8] <= REQ_WDATA[8*b +: 8];
            end
        end
        if (rd_en) dout_q <= mem_q[rd_addr];
    end

    bram_lat_pipe #(
        .DEPTH (RD_LAT - 1),
        .WIDTH (DATA_W + 2)
    ) u_pipe (
        .clk_i (CLK),
        .clr_i (!RSTn),
        .d_i   ({v0_q, l0_q, dout_q}),
        .q_o   (pipe_q)
    );

    assign RD_VALID = pipe_q[DATA_W+1];
    assign RD_LAST  = pipe_q[DATA_W+1] & pipe_q[DATA_W];
    assign RD_DATA  = pipe_q[DATA_W+1] ? pipe_q[DATA_W-1:0] : '0;
endmodule

// File: doc/bram_burst.md
BRAM_BURST -- requirements
Module: bram_burst

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; multiple of 8.
REQ-002 Parameter ADDR_W, default 13: word address width; depth is 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 10: read latency in cycles; legal range 1..32.
REQ-004 Parameter LEN_W, default 3: burst-length field width; maximum burst is 2**LEN_W beats.
REQ-005 Port CLK, input, 1: the only clock; all logic is rising-edge.
REQ-006 Port RSTn, input, 1: synchronous, active-low reset.
REQ-007 Port REQ_VALID, input, 1: request present.
REQ-008 Port REQ_READY, output, 1: request accepted when REQ_VALID and REQ_READY are both high on a CLK edge.
REQ-009 Port REQ_WE, input, 1: 1 = write request, 0 = read request.
REQ-010 Port REQ_ADDR, input, ADDR_W: start word address.
REQ-011 Port REQ_LEN, input, LEN_W: read beats minus 1; ignored for writes.
REQ-012 Port REQ_WSTB, input, DATA_W/8: byte write strobes; bit i enables byte i.
REQ-013 Port REQ_WDATA, input, DATA_W: write data.
REQ-014 Port RD_VALID, output, 1: RD_DATA holds a valid read beat this cycle.
REQ-015 Port RD_DATA, output, DATA_W: read data; 0 whenever RD_VALID is 0.
REQ-016 Port RD_LAST, output, 1: high on the final beat of a burst.

Function
REQ-017 The block SHALL have two states: IDLE and BURST.
REQ-018 In IDLE, REQ_READY SHALL be 1.
REQ-019 In BURST, REQ_READY SHALL be 0.
REQ-020 An accepted write SHALL update only the strobed bytes at REQ_ADDR on the acceptance edge.
REQ-021 An accepted write SHALL leave the block in IDLE and SHALL produce no RD_VALID.
REQ-022 An accepted write with REQ_WSTB = 0 SHALL leave memory unchanged.
REQ-023 An accepted read SHALL issue an array read of REQ_ADDR on the acceptance edge.
REQ-024 If REQ_LEN > 0, an accepted read SHALL enter BURST and issue one further array read per cycle at consecutive addresses until REQ_LEN+1 reads are issued, then return to IDLE.
REQ-025 Burst addresses SHALL wrap modulo 2**ADDR_W (e.g. 0x1FFF is followed by 0x0000 for ADDR_W=13).
REQ-026 Each array read issued on edge k SHALL appear with RD_VALID=1 exactly RD_LAT cycles after edge k.
REQ-027 Beats SHALL be delivered back-to-back, in issue order, with no gaps.
REQ-028 RD_LAST SHALL be 1 only on beat REQ_LEN+1; it is 1 on every single-beat read.
REQ-029 A new request SHALL be acceptable on the cycle after the final burst read is issued, so pipelined reads overlap in flight.
REQ-030 A write accepted while earlier read beats are in flight SHALL NOT alter those beats; reads return the data present at their issue edge (read-first).
REQ-031 There is no output backpressure: the consumer SHALL always accept RD_VALID beats.

Reset
REQ-032 While RSTn=0 at a CLK edge, the state SHALL become IDLE and all in-flight read beats SHALL be discarded.
REQ-033 While RSTn=0 at a CLK edge, RD_VALID, RD_LAST and RD_DATA SHALL become 0.
REQ-034 While RSTn=0 at a CLK edge, REQ_READY SHALL be 0, and it SHALL rise in the first cycle after RSTn returns to 1.
REQ-035 A reset asserted mid-burst SHALL abort the burst; no beat issued before reset SHALL appear afterwards.
REQ-036 Memory contents SHALL NOT be cleared by reset, and no write SHALL occur while RSTn=0.

Structure
REQ-037 The parameter defaults (32, 13, 10, 3) and the state enumeration SHALL live in the shared package bram_pkg.
REQ-038 The array SHALL be inferred as block RAM with a per-byte write enable.
REQ-039 The read-latency delay line for valid, last and data SHALL be one sub-module, bram_lat_pipe, parametrised by DEPTH=RD_LAT-1 and WIDTH=DATA_W+2, with a synchronous clear driven by reset.

Verification
REQ-040 Write 0xDEADBEEF to 0x0010 with strobe 0xF, then read 0x0010 with LEN=0 -> one beat 0xDEADBEEF with RD_LAST=1, exactly 10 cycles after read acceptance.
REQ-041 Write 0x000000AA to 0x0010 with strobe 0x1 -> a subsequent read of 0x0010 returns 0xDEADBEAA.
REQ-042 Preload 0x1FFE..0x0001 with the address values, then read 0x1FFE with LEN=3 -> four contiguous beats 0x1FFE, 0x1FFF, 0x0000, 0x0001; RD_LAST on the fourth; REQ_READY low for 3 cycles.
REQ-043 Read 0x0020 (holding 0x11) and, on the next cycle, write 0x22 to 0x0020 -> the read beat is 0x11; a later read returns 0x22.
REQ-044 Start a LEN=7 burst, assert RSTn=0 on its 3rd cycle for 1 cycle -> no RD_VALID for 12 cycles after release; REQ_READY=1 one cycle after release.
REQ-045 Repeat REQ-040 and REQ-042 with RD_LAT=1 and RD_LAT=32 -> latency matches the parameter and all beats are correct.
